// File: rtl/unishift_ctrl_if.sv
// Command and shift-register bus for unishift_ctrl.
// The slave modport is the controller's view; the master modport is the host/register side.
interface unishift_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic [WIDTH-1:0] q;
    logic [1:0]       sr_sel;
    logic [WIDTH-1:0] sr_in;
    logic             sr_serialright;
    logic             sr_serialleft;
    logic             sr_clr;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, q,
        output cmd_ready, sr_sel, sr_in, sr_serialright, sr_serialleft,
               sr_clr, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, q,
        input  cmd_ready, sr_sel, sr_in, sr_serialright, sr_serialleft,
               sr_clr, busy, done, err
    );
endinterface

// File: rtl/unishift_ctrl.sv
// Command sequencer for a universal shift register: load, clear, N-step shift/rotate.
// Latency accept->done: LOAD/CLEAR 2, shift count+1, zero-count/illegal 1; cmd_ready only in IDLE.
module unishift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            clr,
    unishift_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_SHR   = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_ROR   = 3'd3;
    localparam logic [2:0] OP_ROL   = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;
    localparam logic [1:0] SEL_LOAD  = 2'd3;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fill_q;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] in_q;
    logic             clr_pulse_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             ready_q;

    logic             ser_right_d;
    logic             ser_left_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            fill_q      <= 1'b0;
            sel_q       <= SEL_HOLD;
            in_q        <= '0;
            clr_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q    <= bus.cmd_op;
                        cnt_q   <= bus.cmd_count;
                        fill_q  <= bus.cmd_fill;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        case (bus.cmd_op)
                            OP_LOAD: begin
                                state_q <= S_LOAD;
                                sel_q   <= SEL_LOAD;
                                in_q    <= bus.cmd_data;
                            end
                            OP_CLEAR: begin
                                state_q     <= S_CLEAR;
                                clr_pulse_q <= 1'b1;
                            end
                            OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                                if (bus.cmd_count == '0) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= S_SHIFT;
                                    sel_q   <= (bus.cmd_op == OP_SHR || bus.cmd_op == OP_ROR)
                                               ? SEL_RIGHT : SEL_LEFT;
                                end
                            end
                            default: begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    state_q <= S_DONE;
                    sel_q   <= SEL_HOLD;
                    done_q  <= 1'b1;
                end
                S_CLEAR: begin
                    state_q     <= S_DONE;
                    clr_pulse_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                S_SHIFT: begin
                    // The counter holds the steps still to perform including this cycle.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        sel_q   <= SEL_HOLD;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    sel_q       <= SEL_HOLD;
                    clr_pulse_q <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

    // Rotate feedback comes straight from q so each step sees the previous step's result.
    always_comb begin
        ser_right_d = 1'b0;
        ser_left_d  = 1'b0;
        if (state_q == S_SHIFT) begin
            case (op_q)
                OP_SHR, OP_SHL: begin
                    ser_right_d = fill_q;
                    ser_left_d  = fill_q;
                end
                OP_ROR:  ser_right_d = bus.q[0];
                OP_ROL:  ser_left_d  = bus.q[WIDTH-1];
                default: begin
                    ser_right_d = 1'b0;
                    ser_left_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready      = ready_q;
    assign bus.sr_sel         = sel_q;
    assign bus.sr_in          = in_q;
    assign bus.sr_serialright = ser_right_d;
    assign bus.sr_serialleft  = ser_left_d;
    assign bus.sr_clr         = clr | clr_pulse_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_unishift_ctrl.sv
// Bench for unishift_ctrl: a behavioural shift register plus a command-level result/timing model.
module tb_unishift_ctrl;
    localparam int W  = 4;
    localparam int CW = 3;
    localparam int MASK = (1 << W) - 1;

    logic clk;
    logic clr;
    logic [W-1:0] sr_q;

    int checks;
    int failures;
    int model_q;

    unishift_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    unishift_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register driven by the controller.
    always_ff @(posedge clk or posedge bus.sr_clr) begin
        if (bus.sr_clr) sr_q <= '0;
        else begin
            case (bus.sr_sel)
                2'd1:    sr_q <= {bus.sr_serialright, sr_q[W-1:1]};
                2'd2:    sr_q <= {sr_q[W-2:0], bus.sr_serialleft};
                2'd3:    sr_q <= bus.sr_in;
                default: sr_q <= sr_q;
            endcase
        end
    end
    assign bus.q = sr_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_result(int op, int qin, int data, int count, int fill);
        int k;
        case (op)
            0: return data & MASK;
            5: return 0;
            1: begin
                if (count >= W) return fill ? MASK : 0;
                return ((qin >> count) | (fill ? (MASK & ~(MASK >> count)) : 0)) & MASK;
            end
            2: begin
                if (count >= W) return fill ? MASK : 0;
                return ((qin << count) | (fill ? ((1 << count) - 1) : 0)) & MASK;
            end
            3: begin
                k = count % W;
                return ((qin >> k) | (qin << (W - k))) & MASK;
            end
            4: begin
                k = count % W;
                return ((qin << k) | (qin >> (W - k))) & MASK;
            end
            default: return qin;
        endcase
    endfunction

    function automatic int model_latency(int op, int count);
        if (op == 0 || op == 5) return 2;
        if (op >= 1 && op <= 4) return (count == 0) ? 1 : count + 1;
        return 1;
    endfunction

    function automatic int model_sel_cycles(int op, int count);
        if (op == 0) return 1;
        if (op >= 1 && op <= 4) return count;
        return 0;
    endfunction

    function automatic int model_sel_val(int op);
        if (op == 0) return 3;
        if (op == 1 || op == 3) return 1;
        if (op == 2 || op == 4) return 2;
        return 0;
    endfunction

    // Called at a negedge; returns at the negedge following the done cycle.
    task automatic run_cmd(input int op, input int data, input int count, input int fill);
        int k;
        int sel_cycles;
        bit got_done;
        int exp_q;
        exp_q = model_result(op, model_q, data, count, fill);
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        chk("ready_before", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_data  = W'(data);
        bus.cmd_count = CW'(count);
        bus.cmd_fill  = fill[0];
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_data  = W'($urandom);
        k = 1;
        sel_cycles = 0;
        got_done = 1'b0;
        while (k <= 40) begin
            if (bus.sr_sel != 2'd0) begin
                sel_cycles++;
                chk("sel_val", 32'(bus.sr_sel), 32'(model_sel_val(op)));
                if (bus.sr_sel == 2'd3) chk("sr_in", 32'(bus.sr_in), 32'(data & MASK));
            end
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            chk("busy", 32'(bus.busy), 32'd1);
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("latency", 32'(k), 32'(model_latency(op, count)));
        chk("err", 32'(bus.err), (op >= 6) ? 32'd1 : 32'd0);
        chk("q_result", 32'(sr_q), 32'(exp_q));
        chk("sel_cycles", 32'(sel_cycles), 32'(model_sel_cycles(op, count)));
        model_q = exp_q;
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("ready_after", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_q = 0;
        clr = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;
        bus.cmd_count = '0;
        bus.cmd_fill  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        chk("rst_sel",   32'(bus.sr_sel), 32'd0);
        chk("rst_srclr", 32'(bus.sr_clr), 32'd1);
        chk("rst_q",     32'(sr_q), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("srclr_low", 32'(bus.sr_clr), 32'd0);

        run_cmd(0, 4'b0110, 0, 0);
        run_cmd(1, 0, 2, 1);
        run_cmd(0, 4'b0110, 0, 0);
        run_cmd(2, 0, 3, 1);
        run_cmd(0, 4'b0110, 0, 0);
        run_cmd(3, 0, 1, 0);
        run_cmd(0, 4'b1001, 0, 0);
        run_cmd(4, 0, 5, 0);
        run_cmd(1, 0, 0, 1);
        run_cmd(7, 4'b1111, 3, 1);
        run_cmd(0, 4'b1111, 0, 0);
        run_cmd(5, 0, 0, 0);

        // Abort a long rotate with reset after two shift cycles.
        run_cmd(0, 4'b0110, 0, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd3;
        bus.cmd_count = 3'd7;
        bus.cmd_fill  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        clr = 1'b1;
        #1;
        chk("abort_q", 32'(sr_q), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        clr = 1'b0;
        model_q = 0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_no_done2", 32'(bus.done), 32'd0);
        run_cmd(0, 4'b1010, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unishift_ctrl.md
Name: unishift_ctrl

Overview:
- Command sequencer for the 4-bit universal shift register (UniShiftReg-style: ports q, serialright, serialleft, in, clr, sel).
- Accepts one command per valid/ready handshake: load, clear, N-step shift or N-step rotate.
- Drives the register's sel, in, serialright, serialleft and clr each cycle, and reports completion.
- Sits between a host/control FSM and the shift register.

Parameters:
WIDTH, 4, register width (must be at least 2)
CNT_W, 3, width of the shift-count field; up to 2^CNT_W-1 steps per command

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command; high only in IDLE
cmd_op  input  3  0 LOAD, 1 SHR fill, 2 SHL fill, 3 ROR, 4 ROL, 5 CLEAR, 6-7 illegal
cmd_data  input  WIDTH  parallel load value (LOAD only)
cmd_count  input  CNT_W  number of shift steps (ops 1-4)
cmd_fill  input  1  serial fill bit (ops 1-2)
q  input  WIDTH  current register contents, used for rotate feedback
sr_sel  output  2  register mode: 0 hold, 1 shift right, 2 shift left, 3 parallel load
sr_in  output  WIDTH  register parallel input
sr_serialright  output  1  bit entering the MSB on a right shift
sr_serialleft  output  1  bit entering the LSB on a left shift
sr_clr  output  1  register clear
busy  output  1  command in progress (not IDLE)
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse with done for an illegal op

Behaviour:
- Reset is asynchronous and active-high on clr; one clock, clk. Ports are named clk and clr as elsewhere in the codebase.
- Register semantics:
  - sel=1: q <= {serialright, q[W-1:1]}.
  - sel=2: q <= {q[W-2:0], serialleft}.
  - sel=3: q <= in.
  - sel=0: hold.
- States: IDLE, LOAD, CLEAR, SHIFT, DONE.
- On reset: state IDLE; sr_sel=0, sr_in=0, internal serial bits=0, busy=0, done=0, err=0, cmd_ready=1. sr_clr = clr OR the internal clear pulse (combinational), so the register clears together with the controller.
- Command acceptance: cmd_valid & cmd_ready at a rising edge latches op, data, count and fill. The command must be held stable until accepted.
- IDLE -> LOAD (op 0): one cycle with sr_sel=3 and sr_in=data.
- IDLE -> CLEAR (op 5): one cycle with internal sr_clr=1.
- IDLE -> SHIFT (ops 1-4, count>0): exactly count consecutive cycles with sr_sel=1 (SHR/ROR) or 2 (SHL/ROL). A down-counter loaded with count decrements each SHIFT cycle; exit when it reaches 1.
- IDLE -> DONE directly when op is 1-4 with count=0, or op is 6-7. No register activity; err=1 in DONE for ops 6-7.
- LOAD, CLEAR and final SHIFT -> DONE. DONE lasts one cycle (done=1, sr_sel=0, cmd_ready=0), then -> IDLE.
- Latency from the acceptance edge to the done cycle: LOAD/CLEAR 2 cycles; shift/rotate count+1 cycles; zero-count and illegal ops 1 cycle. Register result is valid in the done cycle.
- Serial bits:
  - Fill ops: sr_serialright = sr_serialleft = latched fill.
  - ROR: sr_serialright = q[0], combinational from q each cycle.
  - ROL: sr_serialleft = q[W-1], combinational from q each cycle.
  - Inactive serial output = 0.
- sr_sel=0 in every state other than LOAD and SHIFT. sr_in holds its last loaded value.
- Counts greater than WIDTH are legal. Fill ops then yield all-fill; rotates wrap modulo WIDTH.
- Reset mid-command: the command is aborted immediately, the register clears through sr_clr, and no done is issued.
- cmd_valid during a busy state is ignored; no queuing.

Test Plan:
- Reset then LOAD 0110 -> sr_sel=3 for 1 cycle, done 2 cycles after acceptance, q=0110, err=0.
- From 0110, SHR fill=1 count=2 -> sr_sel=1 for 2 cycles, q=1011 then 1101, done at acceptance+3.
- From 0110, SHL fill=1 count=3 -> q=1101, 1011, 0111; then ROR count=1 from 0110 -> q=0011.
- LOAD 1001 then ROL count=5 -> q=0011 (wrap past WIDTH), done at acceptance+6; SHR count=0 -> done at acceptance+1, sr_sel stays 0, q unchanged.
- Illegal op 7 -> done and err high for one cycle at acceptance+1, q unchanged; CLEAR from 1111 -> q=0000 at acceptance+2.
- ROR count=7 from 0110, assert clr after 2 shift cycles -> q=0000 immediately, busy=0, no done; after release cmd_ready=1 and a new LOAD 1010 completes normally.
